// File: rtl/biquad_capture_sequencer_if.sv
// Control, status and data bundle between the capture sequencer and its host.
// The master side drives triggers, phase lengths and the ADC stream.
// The slave side (the sequencer) returns the gated stream and status.
interface biquad_capture_sequencer_if #(
    parameter int DWIDTH  = 128,
    parameter int CNTBITS = 16
);
    logic               enable_i;
    logic               capture_i;
    logic               force_i;
    logic [CNTBITS-1:0] delay_len_i;
    logic [CNTBITS-1:0] gate_len_i;
    logic [CNTBITS-1:0] settle_len_i;
    logic [DWIDTH-1:0]  dat_i;
    logic [DWIDTH-1:0]  dat_o;
    logic               gate_o;
    logic               busy_o;
    logic               done_o;
    logic [15:0]        trig_count_o;
    logic [15:0]        miss_count_o;

    modport master (
        output enable_i, capture_i, force_i,
        output delay_len_i, gate_len_i, settle_len_i, dat_i,
        input  dat_o, gate_o, busy_o, done_o, trig_count_o, miss_count_o
    );

    modport slave (
        input  enable_i, capture_i, force_i,
        input  delay_len_i, gate_len_i, settle_len_i, dat_i,
        output dat_o, gate_o, busy_o, done_o, trig_count_o, miss_count_o
    );
endinterface

// File: rtl/biquad_capture_sequencer.sv
// Capture sequencer: on a trigger, runs DELAY -> GATE -> SETTLE phases whose
// lengths are latched at trigger time, gating the ADC stream during GATE.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a trigger; triggers here start a sequence
//   DELAY  | counting down latched delay length, stream held at zero
//   GATE   | stream passed through (one cycle later on dat_o)
//   SETTLE | counting down latched settle length, stream held at zero
module biquad_capture_sequencer #(
    parameter int DWIDTH  = 128,
    parameter int CNTBITS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    biquad_capture_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_GATE   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
    localparam logic [CNTBITS-1:0] CNT_ZERO = '0;

    state_t             state;
    logic [CNTBITS-1:0] cnt;
    logic [CNTBITS-1:0] delay_len;
    logic [CNTBITS-1:0] gate_len;
    logic [CNTBITS-1:0] settle_len;
    logic               cap_q0;
    logic               cap_q1;
    logic [DWIDTH-1:0]  dat_q;
    logic               done_q;
    logic [15:0]        trig_cnt;
    logic [15:0]        miss_cnt;
    logic               rise;
    logic               trigger;

    // A coincident capture edge and force pulse collapse into one trigger.
    assign rise    = cap_q0 & ~cap_q1;
    assign trigger = (rise | bus.force_i) & bus.enable_i;

    assign bus.gate_o       = (state == S_GATE);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.dat_o        = dat_q;
    assign bus.done_o       = done_q;
    assign bus.trig_count_o = trig_cnt;
    assign bus.miss_count_o = miss_cnt;

    // Sequencer FSM, synchronizer, stream gate and trigger statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            delay_len  <= '0;
            gate_len   <= '0;
            settle_len <= '0;
            cap_q0     <= 1'b0;
            cap_q1     <= 1'b0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            trig_cnt   <= '0;
            miss_cnt   <= '0;
        end else begin
            cap_q0 <= bus.capture_i;
            cap_q1 <= cap_q0;
            done_q <= 1'b0;
            dat_q  <= (state == S_GATE) ? bus.dat_i : '0;

            // Busy covers the last cycle of a phase too, so a trigger that
            // lands as the sequence wraps up is still a miss.
            if (trigger && (state != S_IDLE) && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        trig_cnt   <= trig_cnt + 16'd1;
                        delay_len  <= bus.delay_len_i;
                        gate_len   <= bus.gate_len_i;
                        settle_len <= bus.settle_len_i;
                        if (bus.delay_len_i != CNT_ZERO) begin
                            state <= S_DELAY;
                            cnt   <= bus.delay_len_i - CNT_ONE;
                        end else if (bus.gate_len_i != CNT_ZERO) begin
                            state <= S_GATE;
                            cnt   <= bus.gate_len_i - CNT_ONE;
                        end else if (bus.settle_len_i != CNT_ZERO) begin
                            state <= S_SETTLE;
                            cnt   <= bus.settle_len_i - CNT_ONE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (!bus.enable_i) begin
                        state <= S_IDLE;
                    end else if (cnt != CNT_ZERO) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (gate_len != CNT_ZERO) begin
                        state <= S_GATE;
                        cnt   <= gate_len - CNT_ONE;
                    end else if (settle_len != CNT_ZERO) begin
                        state <= S_SETTLE;
                        cnt   <= settle_len - CNT_ONE;
                    end else begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (!bus.enable_i) begin
                        state <= S_IDLE;
                    end else if (cnt != CNT_ZERO) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (settle_len != CNT_ZERO) begin
                        state <= S_SETTLE;
                        cnt   <= settle_len - CNT_ONE;
                    end else begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!bus.enable_i) begin
                        state <= S_IDLE;
                    end else if (cnt != CNT_ZERO) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
